// File: rtl/image_vector_load_sequencer.sv
// Streams LANES-pixel chunks of the 96x96 image from a combinational-read memory to a valid/ready consumer.
// Optional macro IMGSEQ_ADDR_WRAP_EN wraps chunk and lane addresses modulo the image size.
module image_vector_load_sequencer #(
  parameter int IMAGE_WIDTH  = 96,
  parameter int IMAGE_HEIGHT = 96,
  parameter int LANES        = 8,
  parameter int ADDR_W       = 16
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   num_chunks,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [15:0][15:0]   mem_rd,
  output logic [15:0][15:0]   vec_data,
  output logic                vec_valid,
  input  logic                vec_ready,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  localparam int PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [ADDR_W:0] PIX_END = (ADDR_W+1)'(PIXELS);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

  // Handshake: a chunk transfers on a rising CLK edge where vec_valid and vec_ready are both 1;
  // vec_data is held stable while vec_valid=1 and vec_ready=0.
  state_t             state;
  logic [ADDR_W-1:0]  cur_addr;
  logic [ADDR_W-1:0]  remaining;
  logic [ADDR_W-1:0]  next_addr;
  logic [ADDR_W-1:0]  start_addr;
  logic [15:0][15:0]  chunk;
  logic               unused_mem;

  assign mem_addr   = cur_addr;
  assign state_dbg  = state;
  assign unused_mem = ^mem_rd;

`ifdef IMGSEQ_ADDR_WRAP_EN
  logic [ADDR_W:0] wrap_sum;

  // The memory returns already-wrapped pixels, so every live lane is taken as-is.
  always_comb begin
    wrap_sum   = {1'b0, cur_addr} + (ADDR_W+1)'(LANES);
    next_addr  = (wrap_sum >= PIX_END) ? ADDR_W'(wrap_sum - PIX_END) : wrap_sum[ADDR_W-1:0];
    start_addr = ADDR_W'(32'(base_addr) % PIXELS);
    chunk      = '0;
    for (int i = 0; i < LANES; i++) begin
      chunk[i] = {8'h00, mem_rd[i][7:0]};
    end
  end
`else
  logic [ADDR_W:0] lane_addr;

  // Lane address is computed one bit wider so a lane past the image end is never mistaken for in-range.
  always_comb begin
    next_addr  = cur_addr + ADDR_W'(LANES);
    start_addr = base_addr;
    chunk      = '0;
    lane_addr  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_addr = {1'b0, cur_addr} + (ADDR_W+1)'(i);
      if (lane_addr < PIX_END) begin
        chunk[i] = {8'h00, mem_rd[i][7:0]};
      end
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      vec_data  <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cur_addr  <= start_addr;
            remaining <= num_chunks;
            busy      <= 1'b1;
            state     <= (num_chunks == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          vec_data  <= chunk;
          vec_valid <= 1'b1;
          cur_addr  <= next_addr;
          remaining <= remaining - ADDR_W'(1);
          state     <= STREAM;
        end
        STREAM: begin
          if (vec_valid && vec_ready) begin
            if (remaining != '0) begin
              vec_data  <= chunk;
              cur_addr  <= next_addr;
              remaining <= remaining - ADDR_W'(1);
            end else begin
              vec_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          // An empty burst enters here with done low and spends one extra cycle raising it.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_vector_load_sequencer.sv
// Bench for image_vector_load_sequencer: randomized bursts against an image-level reference model,
// with a queue-based scoreboard popped by an independent monitor.
module tb_image_vector_load_sequencer;

  logic              CLK = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [15:0]       base_addr = '0;
  logic [15:0]       num_chunks = '0;
  logic [15:0]       mem_addr;
  logic [15:0][15:0] mem_rd;
  logic [15:0][15:0] vec_data;
  logic              vec_valid;
  logic              vec_ready = 1'b0;
  logic              busy;
  logic              done;
  logic [1:0]        state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic [255:0] exp_q[$];

  image_vector_load_sequencer dut (
    .CLK(CLK), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .num_chunks(num_chunks), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .vec_data(vec_data), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset block
  initial forever #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // image memory: pixel k = (k ^ k>>8) & 0xFF, upper byte and lanes 8..15 filled with junk
  function automatic logic [7:0] pix(input int k);
    int v;
    v = k ^ (k >> 8);
    return v[7:0];
  endfunction

  function automatic logic [15:0][15:0] mem_word(input logic [15:0] a);
    logic [15:0][15:0] w;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] hi;
      hi = 8'h5A + 8'(i);
      w[i] = {hi, pix((int'(a) + i) % 9216)};
    end
    return w;
  endfunction

  assign mem_rd = mem_word(mem_addr);

  // reference model
  function automatic int chunk_addr(input int base, input int k);
`ifdef IMGSEQ_ADDR_WRAP_EN
    return ((base % 9216) + 8 * k) % 9216;
`else
    return (base + 8 * k) % 65536;
`endif
  endfunction

  function automatic logic [255:0] model_chunk(input int a);
    logic [255:0] c;
    int p;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      p = a + i;
`ifdef IMGSEQ_ADDR_WRAP_EN
      c[16*i +: 16] = {8'h00, pix(p % 9216)};
`else
      if (p < 9216) c[16*i +: 16] = {8'h00, pix(p)};
`endif
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ready driver
  initial begin
    int idx = 0;
    forever begin
      @(posedge CLK); #1;
      case (ready_mode)
        0: vec_ready = 1'b1;
        1: vec_ready = (idx % 3 == 0);
        2: vec_ready = 1'($urandom_range(0, 1));
        default: vec_ready = 1'b0;
      endcase
      idx++;
    end
  end

  // monitor / scoreboard
  initial begin
    logic [255:0] held;
    logic [255:0] e;
    bit hold_pend;
    hold_pend = 0;
    held = '0;
    forever begin
      @(negedge CLK);
      if (reset || abort) begin
        hold_pend = 0;
      end else begin
        if (hold_pend && vec_valid) check("stall_stable", vec_data, held);
        if (vec_valid && vec_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_chunk got=%0h exp=none", vec_data);
          end else begin
            e = exp_q.pop_front();
            check("chunk", vec_data, e);
          end
        end
        hold_pend = vec_valid && !vec_ready;
        held = vec_data;
      end
    end
  end

  // driver tasks
  task automatic drive_start(input int base, input int n);
    @(posedge CLK); #1;
    start = 1'b1;
    base_addr = 16'(base);
    num_chunks = 16'(n);
  endtask

  task automatic run_burst(input int base, input int n, input int mode);
    int t;
    bit got;
    ready_mode = mode;
    for (int k = 0; k < n; k++) exp_q.push_back(model_chunk(chunk_addr(base, k)));
    drive_start(base, n);
    t = cyc;
    @(posedge CLK); #1;
    start = 1'b0;
    base_addr = 16'($urandom);
    num_chunks = 16'($urandom);
    @(negedge CLK);
    check("busy_t1", busy, 1);
    check("valid_t1", vec_valid, 0);
    @(negedge CLK);
    check("valid_t2", vec_valid, (n != 0));
    got = 0;
    for (int i = 0; i < 8 * n + 60; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      @(negedge CLK);
    end
    check("done_seen", got, 1);
    if (mode == 0) check("done_cycle", cyc - t, (n == 0) ? 2 : n + 2);
    if (n == 0) check("busy_t2", busy, 1);
    @(negedge CLK);
    check("done_pulse", done, 0);
    check("busy_end", busy, 0);
    check("chunks_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int b, n;
    // reset state
    repeat (2) @(negedge CLK);
    check("rst_valid", vec_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", vec_data, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_state", state_dbg, 0);
    @(posedge CLK); #1;
    reset = 1'b0;

    // directed bursts
    run_burst(0, 4, 0);
    run_burst(0, 4, 1);
    run_burst(9212, 1, 0);
    run_burst(9212, 1, 2);
    run_burst(1234, 0, 0);

    // abort after second handshake of an 8-chunk burst
    ready_mode = 0;
    for (int k = 0; k < 8; k++) exp_q.push_back(model_chunk(chunk_addr(512, k)));
    drive_start(512, 8);
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    abort = 1'b1;
    ready_mode = 3;
    @(posedge CLK); #1;
    abort = 1'b0;
    @(negedge CLK);
    check("abort_valid", vec_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_state", state_dbg, 0);
    check("abort_consumed", exp_q.size(), 6);
    exp_q.delete();
    @(negedge CLK);
    check("abort_no_done", done, 0);
    run_burst(4000, 3, 0);

    // reset mid-stream together with start and ready
    ready_mode = 0;
    for (int k = 0; k < 10; k++) exp_q.push_back(model_chunk(chunk_addr(800, k)));
    drive_start(800, 10);
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    reset = 1'b1;
    start = 1'b1;
    base_addr = 16'd96;
    num_chunks = 16'd5;
    @(negedge CLK);
    @(negedge CLK);
    check("mrst_valid", vec_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_data", vec_data, 0);
    check("mrst_addr", mem_addr, 0);
    check("mrst_state", state_dbg, 0);
    exp_q.delete();
    @(negedge CLK);
    check("mrst_start_ignored", busy, 0);
    @(posedge CLK); #1;
    reset = 1'b0;
    start = 1'b0;

    // randomized bursts
    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 3))
        0: b = $urandom_range(9160, 9215);
        1: b = $urandom_range(65500, 65535);
        default: b = $urandom_range(0, 9215);
      endcase
      n = $urandom_range(0, 12);
      run_burst(b, n, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_vector_load_sequencer.md
# image_vector_load_sequencer

Sequencer that streams the 96×96 8-bit image out of the image data memory as 8-pixel vector chunks. It sits between the vector CPU's load control and the combinational-read image memory. It drives the memory address, registers the 16-lane read word, and presents each chunk to the vector register file with a valid/ready handshake. It runs one burst per `start`, covering `num_chunks` consecutive chunks from `base_addr`.

## Interface
- `IMAGE_WIDTH`, 96, image width in pixels
- `IMAGE_HEIGHT`, 96, image height in pixels
- `LANES`, 8, live pixels per chunk (lanes LANES..15 are always zero)
- `ADDR_W`, 16, memory address width

- `CLK`  in  1  clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin burst; sampled only in IDLE
- `abort`  in  1  cancel burst; returns to IDLE next cycle, no `done`
- `base_addr`  in  16  pixel address of the first chunk
- `num_chunks`  in  16  number of chunks in the burst; captured at `start`
- `mem_addr`  out  16  address to image memory, combinational from the address register
- `mem_rd`  in  16×16  memory read word, combinational from `mem_addr`
- `vec_data`  out  16×16  registered chunk; lane i holds the zero-extended pixel in bits [7:0]
- `vec_valid`  out  1  `vec_data` holds an unconsumed chunk
- `vec_ready`  in  1  consumer accepts `vec_data` this cycle
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse after the last chunk is accepted

## Operation
- States: IDLE, FETCH, STREAM, DONE. Reset value is IDLE.
- IDLE: when `start`=1, capture `base_addr` into `cur_addr` and `num_chunks` into `remaining`.
  - If `num_chunks`=0, go to DONE.
  - Otherwise go to FETCH.
- FETCH, one cycle:
  - Drive `mem_addr`=`cur_addr` and load `vec_data` from `mem_rd` with lane masking.
  - Set `vec_valid`, advance `cur_addr` by LANES, decrement `remaining`, go to STREAM.
- STREAM: on handshake (`vec_valid`&`vec_ready`):
  - If `remaining`≠0, load the next chunk in the same cycle, advance, decrement. `vec_valid` stays 1.
  - If `remaining`=0, clear `vec_valid` and go to DONE.
  - Without handshake, `vec_data` holds stable.
- DONE: assert `done` for one cycle, then return to IDLE.
- Lane masking:
  - Lanes LANES..15 are forced to 0.
  - Lane i with `cur_addr`+i ≥ IMAGE_WIDTH×IMAGE_HEIGHT (9216) is forced to 0.
  - Lanes 0..LANES-1 take `mem_rd[i][7:0]`, zero-extended to 16 bits.
- Address arithmetic is 16-bit unsigned. `cur_addr`+LANES wraps modulo 2^16 when the macro is off.
- `start` while `busy` is ignored.
- `abort` has priority over the handshake. Any state goes to IDLE on the next cycle with `vec_valid`=0 and no `done`.
- `reset` has priority over `abort`.

## Timing
- Reset values:
  - state IDLE
  - `vec_valid`=0, `busy`=0, `done`=0
  - `vec_data`=0, `mem_addr`=0
  - `cur_addr`=0, `remaining`=0
- `start` in cycle t: `busy`=1 at t+1 and `vec_valid`=1 at t+2.
- Throughput is one chunk per cycle while `vec_ready` is held high.
- A burst of N≥1 chunks with `vec_ready` tied high takes N+3 cycles from `start` until `done` falls.
- `done` is asserted in the cycle after the last handshake.
- `num_chunks`=0: `done` pulses at t+2 and `vec_valid` never rises.
- `mem_addr` follows `cur_addr` combinationally. The memory must return `mem_rd` in the same cycle.

## Configuration
- `IMGSEQ_ADDR_WRAP_EN` defined:
  - The chunk base and the per-lane addresses wrap modulo 9216.
  - `mem_addr` never leaves 0..9215.
  - The out-of-range lane mask is disabled; those lanes read wrapped pixels.
- Undefined: no wrap, and out-of-range lanes are zeroed as described in Operation.

## Test plan
- Memory loaded with pixel[k]=k&0xFF; `base_addr`=0, `num_chunks`=4, `vec_ready`=1:
  - Four chunks with lanes 0..7 = 0x00..0x07, 0x08..0x0F, 0x10..0x17, 0x18..0x1F; lanes 8..15 = 0.
  - `done` at cycle t+6.
- Same burst with `vec_ready` toggling 1,0,0,1,…: `vec_data` stays stable while stalled, no chunk is dropped or duplicated, and 4 handshakes total.
- `base_addr`=9212, `num_chunks`=1:
  - Macro off: lanes 0..3 = pixels 9212..9215 and lanes 4..7 = 0.
  - Macro on: lanes 4..7 = pixels 0..3.
- `num_chunks`=0: no `vec_valid`, `done` pulses two cycles after `start`, `busy` is high for exactly 2 cycles.
- `abort` after the second handshake of an 8-chunk burst: next cycle is IDLE with `vec_valid`=0, `busy`=0 and no `done`; a new `start` then restarts from its new `base_addr`.
- `reset` asserted mid-STREAM concurrently with `start` and `vec_ready`: next cycle all outputs are at reset values; `start` is ignored during `reset`.
